rom_bus_adapter: RTL and testbench

//  Host-side front end for the boot ROM array. Accepts req/gnt read requests

---
 rtl/rom_bus_adapter.sv | 161 ++++++++++++++++
 tb/tb_rom_bus_adapter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/rom_bus_adapter.sv
// Host req/gnt front end for the boot ROM: issues one-cycle ROM reads, rejects writes
// and out-of-range addresses, and returns all responses in grant order via a small FIFO.

module rom_bus_adapter_chk #(
    parameter int RspDepth = 2,
    parameter int CW       = 2
) (
    input logic          clk_i,
    input logic          rst_ni,
    input logic          push_i,
    input logic          push_err_i,
    input logic          dvalid_i,
    input logic          pop_i,
    input logic [CW-1:0] count_i
);
    localparam logic [CW-1:0] CountFull = CW'(RspDepth);

    // A good-data push must coincide with the ROM's registered valid strobe.
    a_dvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push_i && !push_err_i) |-> dvalid_i);

    // The grant rule reserves a FIFO slot for every outstanding read.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        push_i |-> (count_i < CountFull));

    // Pop is qualified by rvalid, so it can never hit an empty FIFO.
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop_i |-> (count_i != {CW{1'b0}}));
endmodule

module rom_bus_adapter #(
    parameter int Width    = 32,
    parameter int Depth    = 2048,
    parameter int Aw       = $clog2(Depth),
    parameter int AddrW    = 32,
    parameter int RspDepth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    output logic             gnt_o,
    output logic             rvalid_o,
    output logic [Width-1:0] rdata_o,
    output logic             rerror_o,
    input  logic             rready_i,
    output logic [Aw-1:0]    rom_addr_o,
    output logic             rom_cs_o,
    input  logic [Width-1:0] rom_dout_i,
    input  logic             rom_dvalid_i
);
    localparam int CW = $clog2(RspDepth + 1);
    localparam int PW = $clog2(RspDepth);
    localparam logic [AddrW-3:0] DepthLim = (AddrW-2)'(Depth);
    localparam logic [CW:0]      RspLim   = (CW+1)'(RspDepth);
    localparam logic [PW-1:0]    PtrLast  = PW'(RspDepth - 1);

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic          inflight_q, inflight_d;
    logic          inflight_err_q, inflight_err_d;
    logic [Width:0] mem_q [RspDepth];

    logic             pop_s, push_s, bad_s, gnt_s, room_s;
    logic [CW:0]      occ_s;
    logic [Width:0]   push_word_s;
    logic [Width:0]   head_s;
    logic             addr_unused_s;

    assign addr_unused_s = ^addr_i[1:0];

    // Slots already committed: queued responses plus the read in flight, less the one leaving now.
    assign pop_s  = (count_q != {CW{1'b0}}) & rready_i;
    assign occ_s  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop_s};
    assign room_s = (occ_s < RspLim);
    assign gnt_s  = req_i & room_s;
    assign bad_s  = we_i | (addr_i[AddrW-1:2] >= DepthLim);
    assign push_s = inflight_q;

    assign gnt_o      = gnt_s;
    assign rom_cs_o   = gnt_s & ~bad_s;
    assign rom_addr_o = addr_i[Aw+1:2];

    assign head_s   = mem_q[rptr_q];
    assign rvalid_o = (count_q != {CW{1'b0}});
    assign rdata_o  = rvalid_o ? head_s[Width:1] : {Width{1'b0}};
    assign rerror_o = rvalid_o & head_s[0];

    // Next-state for the in-flight tracker, FIFO pointers and occupancy.
    always_comb begin
        inflight_d     = gnt_s;
        inflight_err_d = gnt_s & bad_s;
        wptr_d         = wptr_q;
        rptr_d         = rptr_q;
        count_d        = count_q;
        if (inflight_err_q) begin
            push_word_s = {{Width{1'b0}}, 1'b1};
        end else begin
            push_word_s = {rom_dout_i, 1'b0};
        end
        if (push_s) begin
            wptr_d = (wptr_q == PtrLast) ? {PW{1'b0}} : wptr_q + PW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = (rptr_q == PtrLast) ? {PW{1'b0}} : rptr_q + PW'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q        <= {CW{1'b0}};
            wptr_q         <= {PW{1'b0}};
            rptr_q         <= {PW{1'b0}};
            inflight_q     <= 1'b0;
            inflight_err_q <= 1'b0;
        end else begin
            count_q        <= count_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            inflight_q     <= inflight_d;
            inflight_err_q <= inflight_err_d;
        end
    end

    // Response storage; each entry is {data, error}.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RspDepth; i++) begin
                mem_q[i] <= {(Width+1){1'b0}};
            end
        end else if (push_s) begin
            mem_q[wptr_q] <= push_word_s;
        end else begin
            mem_q[wptr_q] <= mem_q[wptr_q];
        end
    end

    rom_bus_adapter_chk #(
        .RspDepth (RspDepth),
        .CW       (CW)
    ) u_chk (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (push_s),
        .push_err_i (inflight_err_q),
        .dvalid_i   (rom_dvalid_i),
        .pop_i      (pop_s),
        .count_i    (count_q)
    );
endmodule

// File: tb/tb_rom_bus_adapter.sv
// Self-checking bench for rom_bus_adapter: directed scenarios plus random traffic
// compared against a queue-based model of outstanding responses.

module tb_rom_bus_adapter;
    localparam int DEPTH = 2048;
    localparam int RSP   = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i, we_i, rready_i;
    logic [31:0] addr_i;
    logic        gnt_o, rvalid_o, rerror_o, rom_cs_o;
    logic [31:0] rdata_o;
    logic [10:0] rom_addr_o;
    logic [31:0] rom_dout_i = 32'h0;
    logic        rom_dvalid_i = 1'b0;

    logic [31:0] rom_mem [DEPTH];

    always #5 clk_i = ~clk_i;

    rom_bus_adapter dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .rerror_o     (rerror_o),
        .rready_i     (rready_i),
        .rom_addr_o   (rom_addr_o),
        .rom_cs_o     (rom_cs_o),
        .rom_dout_i   (rom_dout_i),
        .rom_dvalid_i (rom_dvalid_i)
    );

    // Synchronous ROM: data and valid registered one cycle after chip-select.
    always @(posedge clk_i) begin
        rom_dvalid_i <= rom_cs_o;
        if (rom_cs_o) rom_dout_i <= rom_mem[rom_addr_o];
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          rdy;
    } rsp_t;

    rsp_t q[$];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int grants = 0;
    int dut_g = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive inputs after the falling edge, check, then advance the model.
    task automatic step(input logic rq, input logic w, input logic [31:0] a, input logic rr);
        logic rv_e, pop_e, g_e, bad;
        @(negedge clk_i);
        req_i = rq; we_i = w; addr_i = a; rready_i = rr;
        #1;
        rv_e  = (q.size() > 0) && (q[0].rdy <= cyc);
        pop_e = rv_e && rr;
        g_e   = rq && ((q.size() - int'(pop_e)) < RSP);
        bad   = w || (a[31:2] >= DEPTH);
        chk("rvalid", {63'b0, rvalid_o}, {63'b0, rv_e});
        if (rv_e) begin
            chk("rdata", {32'b0, rdata_o}, {32'b0, q[0].data});
            chk("rerror", {63'b0, rerror_o}, {63'b0, q[0].err});
        end
        chk("gnt", {63'b0, gnt_o}, {63'b0, g_e});
        chk("rom_cs", {63'b0, rom_cs_o}, {63'b0, g_e && !bad});
        if (g_e && !bad) chk("rom_addr", {53'b0, rom_addr_o}, {53'b0, a[12:2]});
        if (gnt_o) dut_g++;
        if (pop_e) void'(q.pop_front());
        if (g_e) begin
            q.push_back('{bad ? 32'h0 : rom_mem[a[12:2]], bad, cyc + 2});
            grants++;
        end
        cyc++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"}, {63'b0, gnt_o}, 64'h0);
        chk({tag, "_rvalid"}, {63'b0, rvalid_o}, 64'h0);
        chk({tag, "_rdata"}, {32'b0, rdata_o}, 64'h0);
        chk({tag, "_rerror"}, {63'b0, rerror_o}, 64'h0);
        chk({tag, "_rom_cs"}, {63'b0, rom_cs_o}, 64'h0);
        chk({tag, "_rom_addr"}, {53'b0, rom_addr_o}, 64'h0);
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = $urandom;
        rom_mem[4] = 32'hDEADBEEF;
        rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; rready_i = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single read of word 4.
        step(1'b1, 1'b0, 32'h10, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Eight back-to-back reads.
        dut_g = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'(i * 4), 1'b1);
        chk("t2_grants", 64'(dut_g), 64'd8);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Backpressure: exactly RSP grants, then resume.
        dut_g = 0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'(32'h40 + i * 4), 1'b0);
        chk("t3_stall_grants", 64'(dut_g), 64'(RSP));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'(32'h80 + i * 4), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Write and out-of-range read are errors, interleaved in order.
        step(1'b1, 1'b1, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h2000, 1'b1);
        step(1'b1, 1'b0, 32'h4, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset with one response queued and one in flight.
        step(1'b1, 1'b0, 32'h20, 1'b0);
        step(1'b1, 1'b0, 32'h24, 1'b0);
        @(negedge clk_i);
        req_i = 1'b0; addr_i = 32'h0;
        rst_ni = 1'b0;
        #1;
        chk_reset_outputs("t5");
        #2;
        rst_ni = 1'b1;
        q.delete();
        cyc++;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h8, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Random in-range reads with random backpressure.
        grants = 0;
        for (int i = 0; i < 2000 && grants < 100; i++) begin
            a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            step((($urandom % 4) != 0), 1'b0, a, (($urandom % 2) != 0));
        end
        chk("t6_grants", 64'(grants), 64'd100);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
